// File: rtl/sprite_commit_sched.sv
// Sprite object-table commit scheduler: copies staging into the active table on the
// vsync rising edge after a commit request, and arbitrates the single bitmap RAM port.
module sprite_commit_sched #(
    parameter int OBJ_BYTES = 4,
    parameter int BMP_AW    = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vsync_i,
    input  logic                         visible_i,
    input  logic                         commit_req,
    input  logic                         irq_clr,
    output logic [$clog2(OBJ_BYTES)-1:0] stage_addr,
    input  logic [7:0]                   stage_rdata,
    output logic                         act_we,
    output logic [$clog2(OBJ_BYTES)-1:0] act_addr,
    output logic [7:0]                   act_wdata,
    output logic                         stage_lock,
    output logic                         busy,
    output logic                         irq,
    input  logic                         rend_req,
    input  logic [BMP_AW-1:0]            rend_addr,
    output logic                         rend_gnt,
    input  logic                         hb_req,
    input  logic [BMP_AW-1:0]            hb_addr,
    input  logic [7:0]                   hb_wdata,
    input  logic                         bmp_wr_en,
    output logic                         hb_gnt,
    output logic [BMP_AW-1:0]            bram_addr,
    output logic                         bram_we,
    output logic [7:0]                   bram_wdata
);

    localparam int CW = $clog2(OBJ_BYTES);

    typedef enum logic [1:0] {IDLE, ARMED, COPY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pending;
    logic          vsync_q;
    logic          vs_rise;

    assign vs_rise = vsync_i & ~vsync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            irq     <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            // A set from DONE outranks a simultaneous clear.
            if (state == DONE)
                irq <= 1'b1;
            else if (irq_clr)
                irq <= 1'b0;

            case (state)
                IDLE: begin
                    if (commit_req)
                        state <= ARMED;
                end
                ARMED: begin
                    if (vs_rise) begin
                        state <= COPY;
                        cnt   <= '0;
                    end
                end
                COPY: begin
                    if (commit_req)
                        pending <= 1'b1;
                    // Counter parks at 0 so addresses idle low outside the copy.
                    if (cnt == CW'(OBJ_BYTES - 1)) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= (pending | commit_req) ? ARMED : IDLE;
                    pending <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign stage_lock = (state == COPY);
    assign act_we     = (state == COPY);
    assign stage_addr = cnt;
    assign act_addr   = cnt;
    assign act_wdata  = (state == COPY) ? stage_rdata : 8'h00;

    // Grant is combinational; everything is forced low while reset is held.
    always_comb begin
        rend_gnt   = 1'b0;
        hb_gnt     = 1'b0;
        bram_addr  = '0;
        bram_wdata = 8'h00;
        if (rst_n) begin
            if (visible_i) begin
                rend_gnt = rend_req;
                hb_gnt   = hb_req & ~rend_req;
            end else begin
                hb_gnt   = hb_req;
                rend_gnt = rend_req & ~hb_req;
            end
            bram_addr  = hb_gnt ? hb_addr : rend_addr;
            bram_wdata = hb_wdata;
        end
        bram_we = hb_gnt & bmp_wr_en;
    end

endmodule

// File: tb/tb_sprite_commit_sched.sv
// Self-checking bench for sprite_commit_sched: cycle-by-cycle reference model plus
// directed scenarios with hand-computed literal expectations.
module tb_sprite_commit_sched;

    localparam int OBJ_BYTES = 4;
    localparam int BMP_AW    = 5;
    localparam int AW        = 2;

    logic              clk = 1'b0;
    logic              rst_n, vsync_i, visible_i, commit_req, irq_clr;
    logic [AW-1:0]     stage_addr, act_addr;
    logic [7:0]        stage_rdata, act_wdata;
    logic              act_we, stage_lock, busy, irq;
    logic              rend_req, rend_gnt, hb_req, bmp_wr_en, hb_gnt, bram_we;
    logic [BMP_AW-1:0] rend_addr, hb_addr, bram_addr;
    logic [7:0]        hb_wdata, bram_wdata;

    logic [7:0] stage_mem [OBJ_BYTES];
    logic [7:0] act_mem   [OBJ_BYTES];
    logic [7:0] lit       [OBJ_BYTES];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    sprite_commit_sched #(.OBJ_BYTES(OBJ_BYTES), .BMP_AW(BMP_AW)) dut (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .visible_i(visible_i),
        .commit_req(commit_req), .irq_clr(irq_clr), .stage_addr(stage_addr),
        .stage_rdata(stage_rdata), .act_we(act_we), .act_addr(act_addr),
        .act_wdata(act_wdata), .stage_lock(stage_lock), .busy(busy), .irq(irq),
        .rend_req(rend_req), .rend_addr(rend_addr), .rend_gnt(rend_gnt),
        .hb_req(hb_req), .hb_addr(hb_addr), .hb_wdata(hb_wdata),
        .bmp_wr_en(bmp_wr_en), .hb_gnt(hb_gnt), .bram_addr(bram_addr),
        .bram_we(bram_we), .bram_wdata(bram_wdata)
    );

    always #5 clk = ~clk;

    assign stage_rdata = stage_mem[stage_addr];

    always @(posedge clk)
        if (act_we === 1'b1) act_mem[act_addr] <= act_wdata;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: where the commit is in its life, expressed as flags and a byte index.
    bit m_waiting_vs, m_pend, m_done_now, m_irq, m_vs_prev;
    int m_byte = -1;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_waiting_vs = 0; m_pend = 0; m_done_now = 0; m_irq = 0; m_vs_prev = 0;
            m_byte = -1;
            chk_en = 1;
        end else begin
            bit rise;
            rise = vsync_i && !m_vs_prev;
            m_vs_prev = vsync_i;
            if (m_done_now) m_irq = 1;
            else if (irq_clr) m_irq = 0;
            if (m_done_now) begin
                m_waiting_vs = m_pend || commit_req;
                m_pend = 0;
                m_done_now = 0;
            end else if (m_byte >= 0) begin
                if (commit_req) m_pend = 1;
                m_byte = m_byte + 1;
                if (m_byte == OBJ_BYTES) begin
                    m_byte = -1;
                    m_done_now = 1;
                end
            end else if (m_waiting_vs) begin
                if (rise) begin
                    m_waiting_vs = 0;
                    m_byte = 0;
                end
            end else if (commit_req) begin
                m_waiting_vs = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int win;
            bit copying;
            copying = (m_byte >= 0);
            if (!rst_n) win = 0;
            else if (visible_i) win = rend_req ? 1 : (hb_req ? 2 : 0);
            else win = hb_req ? 2 : (rend_req ? 1 : 0);
            chk("m_busy", 16'(busy), 16'(m_waiting_vs || copying || m_done_now));
            chk("m_stage_lock", 16'(stage_lock), 16'(copying));
            chk("m_act_we", 16'(act_we), 16'(copying));
            chk("m_act_addr", 16'(act_addr), copying ? 16'(m_byte) : 16'd0);
            chk("m_stage_addr", 16'(stage_addr), copying ? 16'(m_byte) : 16'd0);
            chk("m_act_wdata", 16'(act_wdata), copying ? 16'(stage_mem[m_byte]) : 16'd0);
            chk("m_irq", 16'(irq), 16'(m_irq));
            chk("m_rend_gnt", 16'(rend_gnt), 16'(win == 1));
            chk("m_hb_gnt", 16'(hb_gnt), 16'(win == 2));
            chk("m_bram_we", 16'(bram_we), 16'(win == 2 && bmp_wr_en));
            chk("m_bram_addr", 16'(bram_addr),
                (win == 2) ? 16'(hb_addr) : (rst_n ? 16'(rend_addr) : 16'd0));
            chk("m_bram_wdata", 16'(bram_wdata), rst_n ? 16'(hb_wdata) : 16'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; vsync_i = 0; visible_i = 0; commit_req = 0; irq_clr = 0;
        rend_req = 0; rend_addr = '0; hb_req = 0; hb_addr = '0; hb_wdata = '0; bmp_wr_en = 0;
        stage_mem[0] = 8'hA1; stage_mem[1] = 8'hB2; stage_mem[2] = 8'hC3; stage_mem[3] = 8'hD4;
        lit[0] = 8'hA1; lit[1] = 8'hB2; lit[2] = 8'hC3; lit[3] = 8'hD4;

        // Reset: outputs low even with a host request pending
        step; hb_req = 1; bmp_wr_en = 1;
        step;
        @(negedge clk);
        chk("rst_hb_gnt", 16'(hb_gnt), 16'd0);
        chk("rst_bram_we", 16'(bram_we), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_irq", 16'(irq), 16'd0);
        hb_req = 0; bmp_wr_en = 0; rst_n = 1;

        // Basic commit then copy on vsync rise
        step; commit_req = 1;
        @(negedge clk); chk("s1_busy_before", 16'(busy), 16'd0);
        step; commit_req = 0;
        @(negedge clk); chk("s1_busy_armed", 16'(busy), 16'd1);
        repeat (3) step;
        vsync_i = 1;
        @(negedge clk); chk("s1_no_we_on_edge", 16'(act_we), 16'd0);
        for (int i = 0; i < OBJ_BYTES; i++) begin
            step;
            @(negedge clk);
            chk("s1_act_we", 16'(act_we), 16'd1);
            chk("s1_act_addr", 16'(act_addr), 16'(i));
            chk("s1_act_wdata", 16'(act_wdata), 16'(lit[i]));
        end
        step;
        @(negedge clk);
        chk("s1_done_we", 16'(act_we), 16'd0);
        chk("s1_done_busy", 16'(busy), 16'd1);
        chk("s1_done_irq", 16'(irq), 16'd0);
        step;
        @(negedge clk);
        chk("s1_irq", 16'(irq), 16'd1);
        chk("s1_idle_busy", 16'(busy), 16'd0);
        for (int i = 0; i < OBJ_BYTES; i++) chk("s1_act_mem", 16'(act_mem[i]), 16'(lit[i]));
        vsync_i = 0;

        // Commit during copy re-arms; irq/clear interaction
        step; irq_clr = 1;
        step; irq_clr = 0;
        @(negedge clk); chk("s2_irq_cleared", 16'(irq), 16'd0);
        step; commit_req = 1;
        step; commit_req = 0;
        step; vsync_i = 1;
        step; step; commit_req = 1;
        step; commit_req = 0;
        step;
        step;
        @(negedge clk); chk("s2_done_busy", 16'(busy), 16'd1);
        step;
        @(negedge clk);
        chk("s2_rearmed_busy", 16'(busy), 16'd1);
        chk("s2_irq_set", 16'(irq), 16'd1);
        chk("s2_rearmed_we", 16'(act_we), 16'd0);
        vsync_i = 0;
        step; irq_clr = 1;
        step; irq_clr = 0;
        @(negedge clk); chk("s3_irq_clr", 16'(irq), 16'd0);
        step; vsync_i = 1;
        step;
        @(negedge clk); chk("s2_second_copy", 16'(act_we), 16'd1);
        repeat (4) step;
        irq_clr = 1;
        @(negedge clk); chk("s3_in_done_busy", 16'(busy), 16'd1);
        step; irq_clr = 0;
        @(negedge clk);
        chk("s3_set_wins", 16'(irq), 16'd1);
        chk("s3_idle", 16'(busy), 16'd0);
        step; irq_clr = 1;
        step; irq_clr = 0;
        @(negedge clk); chk("s3_clr_alone", 16'(irq), 16'd0);
        vsync_i = 0;

        // Bitmap arbiter
        step;
        visible_i = 1; rend_req = 1; rend_addr = 5'd9; hb_req = 1; hb_addr = 5'd5;
        hb_wdata = 8'h3C; bmp_wr_en = 1;
        @(negedge clk);
        chk("s4_rend_gnt", 16'(rend_gnt), 16'd1);
        chk("s4_hb_gnt", 16'(hb_gnt), 16'd0);
        chk("s4_bram_addr_rend", 16'(bram_addr), 16'd9);
        step; visible_i = 0;
        @(negedge clk);
        chk("s4_hb_gnt_blank", 16'(hb_gnt), 16'd1);
        chk("s4_rend_gnt_blank", 16'(rend_gnt), 16'd0);
        chk("s4_bram_we", 16'(bram_we), 16'd1);
        chk("s4_bram_addr", 16'(bram_addr), 16'd5);
        chk("s4_bram_wdata", 16'(bram_wdata), 16'h3C);
        step; bmp_wr_en = 0;
        @(negedge clk);
        chk("s5_hb_gnt", 16'(hb_gnt), 16'd1);
        chk("s5_bram_we", 16'(bram_we), 16'd0);
        step; rend_req = 0; hb_req = 0;
        @(negedge clk);
        chk("s5_idle_we", 16'(bram_we), 16'd0);
        chk("s5_idle_addr", 16'(bram_addr), 16'd9);

        // Reset in the 2nd copy cycle aborts; a fresh commit copies all bytes
        step; commit_req = 1;
        step; commit_req = 0;
        step; vsync_i = 1;
        step;
        step; rst_n = 0; vsync_i = 0;
        step;
        @(negedge clk);
        chk("s6_act_we", 16'(act_we), 16'd0);
        chk("s6_busy", 16'(busy), 16'd0);
        chk("s6_lock", 16'(stage_lock), 16'd0);
        chk("s6_irq", 16'(irq), 16'd0);
        chk("s6_act_addr", 16'(act_addr), 16'd0);
        rst_n = 1;
        stage_mem[0] = 8'h11; stage_mem[1] = 8'h22; stage_mem[2] = 8'h33; stage_mem[3] = 8'h44;
        lit[0] = 8'h11; lit[1] = 8'h22; lit[2] = 8'h33; lit[3] = 8'h44;
        step; commit_req = 1;
        step; commit_req = 0;
        step; vsync_i = 1;
        repeat (6) step;
        @(negedge clk);
        chk("s6_irq_after", 16'(irq), 16'd1);
        chk("s6_busy_after", 16'(busy), 16'd0);
        for (int i = 0; i < OBJ_BYTES; i++) chk("s6_act_mem", 16'(act_mem[i]), 16'(lit[i]));

        step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_commit_sched.md
Name: sprite_commit_sched

Overview:
- Frame-synchronous controller for the sprite object tables and the bitmap RAM port.
- Host writes go to the staging object table. A commit request arms a copy of staging into the active table, and the copy runs at the next vsync rising edge, so the renderer never sees a half-updated table.
- The block also arbitrates the single bitmap RAM port between renderer reads and host writes.
- It sits between the TinyQV register decode and the video renderer.

Parameters:
OBJ_BYTES, 4, bytes in each object table; the copy length.
BMP_AW, 5, bitmap RAM address width.

Ports:
clk  in  1  clock
rst_n  in  1  reset
vsync_i  in  1  vsync level from the video controller
visible_i  in  1  active-video flag
commit_req  in  1  one-cycle pulse from a control write with the commit bit set
irq_clr  in  1  one-cycle pulse; clears irq
stage_addr  out  $clog2(OBJ_BYTES)  staging RAM read address
stage_rdata  in  8  staging RAM read data, combinational
act_we  out  1  active RAM write enable
act_addr  out  $clog2(OBJ_BYTES)  active RAM write address
act_wdata  out  8  active RAM write data
stage_lock  out  1  high during COPY; the decoder must not write staging while it is high
busy  out  1  high whenever the FSM is not in IDLE
irq  out  1  sticky commit-done interrupt
rend_req  in  1  renderer bitmap read request
rend_addr  in  BMP_AW  renderer bitmap address
rend_gnt  out  1  renderer granted this cycle
hb_req  in  1  host bitmap write request, held until granted
hb_addr  in  BMP_AW  host bitmap address
hb_wdata  in  8  host bitmap data
bmp_wr_en  in  1  bitmap write enable from the control register
hb_gnt  out  1  host request consumed this cycle
bram_addr  out  BMP_AW  bitmap RAM address
bram_we  out  1  bitmap RAM write enable
bram_wdata  out  8  bitmap RAM write data

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk.
  - All outputs are 0 in reset.
  - FSM goes to IDLE; the copy counter, pending flag, irq and the vsync edge register are cleared.
  - Reset asserted mid-COPY aborts the copy. Bytes already written to the active table stay written. No irq is raised.
- vsync edge detection: vs_rise = vsync_i & ~vsync_q, where vsync_q is vsync_i registered.
- FSM states: IDLE, ARMED, COPY, DONE.
  - IDLE → ARMED on commit_req.
  - ARMED → COPY on vs_rise; the counter is loaded with 0.
  - commit_req and vs_rise in the same cycle while in IDLE: go to ARMED only. The copy waits for the next vs_rise.
  - commit_req while already ARMED: no effect.
  - COPY:
    - act_we=1, act_addr=stage_addr=cnt, act_wdata=stage_rdata.
    - cnt increments every cycle.
    - After the cycle with cnt=OBJ_BYTES-1, go to DONE.
    - The copy takes exactly OBJ_BYTES cycles.
  - DONE: lasts one cycle and sets irq.
    - Next state is ARMED if pending=1, else IDLE; pending is cleared on leaving DONE.
  - commit_req during COPY or DONE sets pending.
- Lock and busy:
  - stage_lock=1 only in COPY.
  - busy=1 in ARMED, COPY and DONE.
- irq:
  - Set in DONE, cleared by irq_clr.
  - Set and clear in the same cycle: set wins.
  - irq stays high until cleared.
- Bitmap arbiter (combinational grant, single port):
  - visible_i=1: renderer has priority. rend_gnt = rend_req; hb_gnt = hb_req & ~rend_req.
  - visible_i=0: host has priority. hb_gnt = hb_req; rend_gnt = rend_req & ~hb_req.
  - bram_addr = hb_addr when hb_gnt=1, else rend_addr.
  - bram_we = hb_gnt & bmp_wr_en. If bmp_wr_en=0, the host request is still granted, so it is consumed and the write is dropped.
  - bram_wdata = hb_wdata.
  - No request: bram_we=0, bram_addr = rend_addr.

Test Plan:
1. Reset, then commit_req pulse at t=10 and vsync rising at t=50.
   - Required: busy=1 from t=11.
   - act_we high for 4 cycles starting at t=51 (one cycle for edge detect), act_addr 0,1,2,3.
   - act_wdata equals staging bytes 0xA1,0xB2,0xC3,0xD4.
   - irq=1 after DONE; busy=0 the cycle after DONE.
2. commit_req during COPY.
   - Required: after DONE the FSM goes to ARMED (busy stays 1), and a second copy starts on the next vsync edge.
   - irq is set once; it is not cleared by the re-arm.
3. irq_clr and DONE in the same cycle → irq=1. A later irq_clr alone → irq=0.
4. visible_i=1 with rend_req=1 and hb_req=1, hb_addr=5, hb_wdata=0x3C, bmp_wr_en=1.
   - Required: rend_gnt=1, hb_gnt=0.
   - Drop visible_i → hb_gnt=1, bram_we=1, bram_addr=5, bram_wdata=0x3C.
5. bmp_wr_en=0 with hb_req=1 and visible_i=0 → hb_gnt=1, bram_we=0.
6. Reset asserted at the 2nd COPY cycle.
   - Required: all outputs 0 next cycle, FSM in IDLE, no irq.
   - A new commit_req followed by vsync performs a full 4-byte copy.
